clk_div_ctrl: RTL and testbench

CLK_DIV_CTRL -- requirements
Module: clk_div_ctrl

---
 rtl/clk_div_ctrl.sv | 134 +++++++++++++
 tb/tb_clk_div_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_ctrl.sv
//==============================================================================
// Module      : clk_div_ctrl
// Description : Programmable tick/clock divider with a glitch-free divisor
//               update handshake (IDLE / RUN / PEND control FSM).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module clk_div_ctrl #(
    parameter int unsigned CNT_W   = 29,
    parameter int unsigned DEF_DIV = 49999
) (
    input  logic             clk_100mhz,
    input  logic             rst,
    input  logic             en,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             tick,
    output logic             clk_out,
    output logic             running,
    output logic [CNT_W-1:0] div_cur
);

    localparam logic [CNT_W-1:0] C_DEF_DIV = CNT_W'(DEF_DIV);
    localparam logic [CNT_W-1:0] C_ONE     = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] div_q,   div_d;
    logic [CNT_W-1:0] pend_q,  pend_d;
    logic             tick_q,  tick_d;
    logic             clko_q,  clko_d;
    logic             run_q,   run_d;

    logic w_accept;
    logic w_wrap;

    assign cfg_ready = (state_q != ST_PEND);
    assign w_accept  = cfg_valid && cfg_ready;
    assign w_wrap    = (count_q == div_q);

    always_ff @(posedge clk_100mhz or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            div_q   <= C_DEF_DIV;
            pend_q  <= C_DEF_DIV;
            tick_q  <= 1'b0;
            clko_q  <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            div_q   <= div_d;
            pend_q  <= pend_d;
            tick_q  <= tick_d;
            clko_q  <= clko_d;
            run_q   <= run_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        div_d   = div_q;
        pend_d  = pend_q;
        tick_d  = 1'b0;
        clko_d  = clko_q;

        case (state_q)
            ST_IDLE: begin
                count_d = '0;
                if (w_accept) begin
                    div_d = cfg_div;
                end
                if (en) begin
                    state_d = ST_RUN;
                end
            end

            ST_RUN, ST_PEND: begin
                if (!en) begin
                    state_d = ST_IDLE;
                    count_d = '0;
                    // A divisor still waiting for a wrap takes effect on stop.
                    if (state_q == ST_PEND) begin
                        div_d = pend_q;
                    end else if (w_accept) begin
                        div_d = cfg_div;
                    end
                end else begin
                    if (w_wrap) begin
                        count_d = '0;
                        tick_d  = 1'b1;
                        clko_d  = ~clko_q;
                        if (state_q == ST_PEND) begin
                            div_d   = pend_q;
                            state_d = ST_RUN;
                        end
                    end else begin
                        count_d = count_q + C_ONE;
                    end
                    // Held until the next wrap, even if offered on a wrap edge.
                    if (w_accept) begin
                        pend_d  = cfg_div;
                        state_d = ST_PEND;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
                count_d = '0;
            end
        endcase

        run_d = (state_d != ST_IDLE);
    end

    assign tick    = tick_q;
    assign clk_out = clko_q;
    assign running = run_q;
    assign div_cur = div_q;

endmodule

`default_nettype wire

// File: tb/tb_clk_div_ctrl.sv
//==============================================================================
// Module      : tb_clk_div_ctrl
// Description : Scoreboard bench for clk_div_ctrl with hand-timed tick events.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_clk_div_ctrl;

    localparam int unsigned W   = 16;
    localparam int unsigned DEF = 4;

    logic         clk_100mhz = 1'b0;
    logic         rst        = 1'b1;
    logic         en         = 1'b0;
    logic         cfg_valid  = 1'b0;
    logic [W-1:0] cfg_div    = '0;
    logic         cfg_ready;
    logic         tick;
    logic         clk_out;
    logic         running;
    logic [W-1:0] div_cur;

    clk_div_ctrl #(
        .CNT_W   (W),
        .DEF_DIV (DEF)
    ) u_dut (
        .clk_100mhz (clk_100mhz),
        .rst        (rst),
        .en         (en),
        .cfg_valid  (cfg_valid),
        .cfg_div    (cfg_div),
        .cfg_ready  (cfg_ready),
        .tick       (tick),
        .clk_out    (clk_out),
        .running    (running),
        .div_cur    (div_cur)
    );

    always #5 clk_100mhz = ~clk_100mhz;

    int cyc = 0;
    always @(posedge clk_100mhz) cyc <= cyc + 1;

    typedef struct {
        int           at;
        logic         clk;
        logic [W-1:0] div;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push(input int at, input logic c, input int d);
        exp_t e;
        e.at  = at;
        e.clk = c;
        e.div = W'(d);
        exp_q.push_back(e);
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk_100mhz);
    endtask

    // Every observed tick must match the next expected event.
    always @(negedge clk_100mhz) begin
        if (!rst && tick) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_tick: got tick at cycle %0d, required none", cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("tick_cycle", cyc, e.at);
                chk("tick_clk_out", {31'd0, clk_out}, {31'd0, e.clk});
                chk("tick_div_cur", {16'd0, div_cur}, {16'd0, e.div});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        int b;

        // Reset values
        repeat (2) @(negedge clk_100mhz);
        chk("rst_tick", {31'd0, tick}, 0);
        chk("rst_clk_out", {31'd0, clk_out}, 0);
        chk("rst_running", {31'd0, running}, 0);
        chk("rst_cfg_ready", {31'd0, cfg_ready}, 1);
        chk("rst_div_cur", {16'd0, div_cur}, DEF);

        // Default divisor, run straight out of reset
        rst = 1'b0;
        b   = cyc;
        en  = 1'b1;
        push(b + 6, 1'b1, 4);
        push(b + 11, 1'b0, 4);
        push(b + 16, 1'b1, 4);
        wait_cyc(b + 1);
        chk("s1_running", {31'd0, running}, 1);
        wait_cyc(b + 16);
        en = 1'b0;
        wait_cyc(b + 17);
        chk("s1_stop_running", {31'd0, running}, 0);
        chk("s1_stop_tick", {31'd0, tick}, 0);
        chk("s1_stop_clk_out", {31'd0, clk_out}, 1);

        // Divisor load in IDLE, then run
        b         = cyc;
        cfg_valid = 1'b1;
        cfg_div   = 16'd9;
        wait_cyc(b + 1);
        cfg_valid = 1'b0;
        chk("s2_div_cur", {16'd0, div_cur}, 9);
        chk("s2_idle", {31'd0, running}, 0);
        en = 1'b1;
        push(b + 12, 1'b0, 9);
        push(b + 22, 1'b1, 9);
        wait_cyc(b + 22);
        en = 1'b0;
        wait_cyc(b + 23);

        // Mid-period update: old divisor finishes its period
        b         = cyc;
        cfg_valid = 1'b1;
        cfg_div   = 16'd4;
        wait_cyc(b + 1);
        cfg_valid = 1'b0;
        en        = 1'b1;
        push(b + 7, 1'b0, 1);
        push(b + 9, 1'b1, 1);
        push(b + 11, 1'b0, 1);
        wait_cyc(b + 4);
        cfg_valid = 1'b1;
        cfg_div   = 16'd1;
        wait_cyc(b + 5);
        cfg_valid = 1'b0;
        chk("s3_pend_ready", {31'd0, cfg_ready}, 0);
        chk("s3_pend_div", {16'd0, div_cur}, 4);
        wait_cyc(b + 7);
        chk("s3_run_ready", {31'd0, cfg_ready}, 1);
        wait_cyc(b + 11);
        en = 1'b0;
        wait_cyc(b + 12);

        // Update accepted exactly on a wrap edge
        b         = cyc;
        cfg_valid = 1'b1;
        cfg_div   = 16'd4;
        wait_cyc(b + 1);
        cfg_valid = 1'b0;
        en        = 1'b1;
        push(b + 7, 1'b1, 4);
        push(b + 12, 1'b0, 7);
        push(b + 20, 1'b1, 7);
        push(b + 28, 1'b0, 7);
        wait_cyc(b + 6);
        cfg_valid = 1'b1;
        cfg_div   = 16'd7;
        wait_cyc(b + 7);
        cfg_valid = 1'b0;
        chk("s4_pend_ready", {31'd0, cfg_ready}, 0);
        chk("s4_pend_div", {16'd0, div_cur}, 4);
        wait_cyc(b + 28);
        en = 1'b0;
        wait_cyc(b + 29);

        // Stop while a divisor is pending
        b  = cyc;
        en = 1'b1;
        wait_cyc(b + 2);
        cfg_valid = 1'b1;
        cfg_div   = 16'd3;
        wait_cyc(b + 3);
        cfg_valid = 1'b0;
        chk("s5_pend_ready", {31'd0, cfg_ready}, 0);
        wait_cyc(b + 4);
        en = 1'b0;
        wait_cyc(b + 5);
        chk("s5_running", {31'd0, running}, 0);
        chk("s5_tick", {31'd0, tick}, 0);
        chk("s5_clk_out", {31'd0, clk_out}, 0);
        chk("s5_div_cur", {16'd0, div_cur}, 3);
        chk("s5_ready", {31'd0, cfg_ready}, 1);

        // Asynchronous reset between edges while PEND
        b  = cyc;
        en = 1'b1;
        push(b + 5, 1'b1, 3);
        wait_cyc(b + 6);
        cfg_valid = 1'b1;
        cfg_div   = 16'd2;
        wait_cyc(b + 7);
        cfg_valid = 1'b0;
        en        = 1'b0;
        chk("s6_pend_ready", {31'd0, cfg_ready}, 0);
        #2 rst = 1'b1;
        #1;
        chk("s6_arst_tick", {31'd0, tick}, 0);
        chk("s6_arst_clk_out", {31'd0, clk_out}, 0);
        chk("s6_arst_running", {31'd0, running}, 0);
        chk("s6_arst_div_cur", {16'd0, div_cur}, DEF);
        chk("s6_arst_ready", {31'd0, cfg_ready}, 1);
        @(negedge clk_100mhz);
        rst = 1'b0;
        b   = cyc;
        en  = 1'b1;
        push(b + 6, 1'b1, 4);
        push(b + 11, 1'b0, 4);
        wait_cyc(b + 11);
        en = 1'b0;
        wait_cyc(b + 12);
        chk("s6_stop_tick", {31'd0, tick}, 0);

        // Divisor zero: tick every cycle, clk_out at half rate
        b         = cyc;
        cfg_valid = 1'b1;
        cfg_div   = 16'd0;
        wait_cyc(b + 1);
        cfg_valid = 1'b0;
        en        = 1'b1;
        push(b + 3, 1'b1, 0);
        push(b + 4, 1'b0, 0);
        push(b + 5, 1'b1, 0);
        push(b + 6, 1'b0, 0);
        wait_cyc(b + 6);
        en = 1'b0;
        wait_cyc(b + 7);
        chk("s7_stop_tick", {31'd0, tick}, 0);
        chk("s7_stop_clk_out", {31'd0, clk_out}, 0);

        repeat (3) @(negedge clk_100mhz);
        while (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_tests++;
            n_fail++;
            $display("FAIL missing_tick: got no tick, required tick at cycle %0d", e.at);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
